uart_link_tester: RTL and testbench

UART_LINK_TESTER -- requirements
Module: uart_link_tester

---
 rtl/uart_link_tester.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_link_tester.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_link_tester.sv
// rtl/uart_link_tester.sv - UART PRBS loopback link tester with APB control and error counters
// A TX PRBS stream is checked against a matching RX PRBS; counters and flags report link quality.
module uart_link_tester #(
  parameter int DATA_BITS    = 8,
  parameter int BAUD_DIV     = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int NUM_FRAMES   = 256,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       TX,
  input  logic       RX,
  output logic       FINISHED,
  output logic       FAILED
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [15:0] FRAMES    = 16'(NUM_FRAMES);
  localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_BITS * BAUD_DIV);
  localparam logic        ODD       = (PARITY_ODD != 0);
  localparam logic        PAR_ON    = (PARITY_EN != 0);

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  logic        busy, finished, failed;
  logic [15:0] rxcnt;
  logic [7:0]  dataerr, parerr, frmerr;
  logic [31:0] to_cnt;
  logic        wr_ctrl, abort, start, run_done, timeout_hit, end_run;
  logic        unused_pwdata;

  assign wr_ctrl       = PSEL && PENABLE && PWRITE && (PADDR == 5'h00);
  assign abort         = wr_ctrl && PWDATA[1];
  assign start         = wr_ctrl && PWDATA[0] && !PWDATA[1] && !busy;
  assign unused_pwdata = ^PWDATA[7:2];

  // ---------------- transmitter ----------------
  state_t      tx_state, tx_next;
  logic [15:0] tx_cnt, tx_lfsr, tx_frames;
  logic [3:0]  tx_bit;
  logic        tx_bit_done, tx_par;

  assign tx_bit_done = (tx_cnt == BIT_LAST);
  assign tx_par      = (^tx_lfsr[DATA_BITS-1:0]) ^ ODD;

  always_comb begin
    tx_next = tx_state;
    TX      = 1'b1;
    case (tx_state)
      S_IDLE:   if (start) tx_next = S_START;
      S_START: begin
        TX = 1'b0;
        if (tx_bit_done) tx_next = S_DATA;
      end
      S_DATA: begin
        TX = tx_lfsr[tx_bit];
        if (tx_bit_done && tx_bit == LAST_BIT) tx_next = PAR_ON ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        TX = tx_par;
        if (tx_bit_done) tx_next = S_STOP;
      end
      S_STOP:   if (tx_bit_done) tx_next = S_GAP;
      S_GAP:    if (tx_bit_done) tx_next = (tx_frames == FRAMES) ? S_IDLE : S_START;
      default:  tx_next = S_IDLE;
    endcase
    if (abort || end_run) tx_next = S_IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_lfsr   <= SEED;
      tx_frames <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_bit_done || tx_next != tx_state || tx_state == S_IDLE) tx_cnt <= '0;
      else tx_cnt <= tx_cnt + 16'd1;
      if (tx_state != S_DATA) tx_bit <= '0;
      else if (tx_bit_done) tx_bit <= tx_bit + 4'd1;
      if (start) begin
        tx_lfsr   <= SEED;
        tx_frames <= '0;
      end else if (tx_state == S_STOP && tx_bit_done) begin
        tx_lfsr   <= lfsr_step(tx_lfsr);
        tx_frames <= tx_frames + 16'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  state_t                rx_state, rx_next;
  logic                  rx_s1, rx_s2, rx_d, rx_fall, rx_sample, rx_par, stop_sample;
  logic [15:0]           rx_cnt, rx_lfsr;
  logic [3:0]            rx_bit;
  logic [DATA_BITS-1:0]  rx_data;
  logic                  data_err, par_err, frm_err;

  assign rx_fall     = rx_d && !rx_s2;
  assign rx_sample   = (rx_state == S_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BIT_LAST);
  assign stop_sample = (rx_state == S_STOP) && rx_sample && !abort;
  assign data_err    = (rx_data != rx_lfsr[DATA_BITS-1:0]);
  assign par_err     = PAR_ON && (rx_par != ((^rx_data) ^ ODD));
  assign frm_err     = !rx_s2;

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_fall) rx_next = S_START;
      S_START:  if (rx_sample) rx_next = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (rx_sample && rx_bit == LAST_BIT) rx_next = PAR_ON ? S_PARITY : S_STOP;
      S_PARITY: if (rx_sample) rx_next = S_STOP;
      S_STOP:   if (rx_sample) rx_next = S_IDLE;
      default:  rx_next = S_IDLE;
    endcase
    if (abort || end_run) rx_next = S_IDLE;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_d     <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_par   <= 1'b0;
      rx_lfsr  <= SEED;
    end else begin
      rx_s1    <= RX;
      rx_s2    <= rx_s1;
      rx_d     <= rx_s2;
      rx_state <= rx_next;
      if (rx_sample || rx_next != rx_state || rx_state == S_IDLE) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      if (rx_state != S_DATA) rx_bit <= '0;
      else if (rx_sample) rx_bit <= rx_bit + 4'd1;
      // LSB arrives first, so shift in from the top
      if (rx_state == S_DATA && rx_sample) rx_data <= {rx_s2, rx_data[DATA_BITS-1:1]};
      if (rx_state == S_PARITY && rx_sample) rx_par <= rx_s2;
      if (start) rx_lfsr <= SEED;
      else if (stop_sample) rx_lfsr <= lfsr_step(rx_lfsr);
    end
  end

  // ---------------- run control and counters ----------------
  assign run_done    = busy && stop_sample && (rxcnt + 16'd1 == FRAMES);
  assign timeout_hit = busy && !stop_sample && (to_cnt == TO_LIMIT);
  assign end_run     = run_done || timeout_hit;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      busy     <= 1'b0;
      finished <= 1'b0;
      failed   <= 1'b0;
      rxcnt    <= '0;
      dataerr  <= '0;
      parerr   <= '0;
      frmerr   <= '0;
      to_cnt   <= '0;
    end else if (abort) begin
      busy     <= 1'b0;
      finished <= 1'b1;
      failed   <= 1'b1;
    end else if (start) begin
      busy     <= 1'b1;
      finished <= 1'b0;
      failed   <= 1'b0;
      rxcnt    <= '0;
      dataerr  <= '0;
      parerr   <= '0;
      frmerr   <= '0;
      to_cnt   <= '0;
    end else begin
      if (stop_sample) begin
        rxcnt  <= rxcnt + 16'd1;
        to_cnt <= '0;
        if (data_err && dataerr != 8'hFF) dataerr <= dataerr + 8'd1;
        if (par_err && parerr != 8'hFF) parerr <= parerr + 8'd1;
        if (frm_err && frmerr != 8'hFF) frmerr <= frmerr + 8'd1;
        if (data_err || par_err || frm_err) failed <= 1'b1;
      end else if (busy) begin
        to_cnt <= to_cnt + 32'd1;
      end
      if (timeout_hit) failed <= 1'b1;
      if (end_run) begin
        busy     <= 1'b0;
        finished <= 1'b1;
      end
    end
  end

  always_comb begin
    PRDATA = 8'h00;
    case (PADDR)
      5'h04:   PRDATA = {5'b0, busy, failed, finished};
      5'h08:   PRDATA = rxcnt[7:0];
      5'h0C:   PRDATA = rxcnt[15:8];
      5'h10:   PRDATA = dataerr;
      5'h14:   PRDATA = parerr;
      5'h18:   PRDATA = frmerr;
      default: PRDATA = 8'h00;
    endcase
  end

  assign FINISHED = finished;
  assign FAILED   = failed;

endmodule

// File: tb/tb_uart_link_tester.sv
// tb/tb_uart_link_tester.sv - directed bench for uart_link_tester
// DUT1: defaults with BAUD_DIV=4 in loopback; DUT2: 7-bit odd parity, 4 frames.
module tb_uart_link_tester;

  logic       PCLK, PRESETN, PSEL, PSEL2, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA, PRDATA2;
  logic       TX, TX2, RX, RX2, FINISHED, FINISHED2, FAILED, FAILED2;
  logic       force0, inv, glitch;
  int         checks, errors;

  localparam int FRAME1 = 12 * 4;
  localparam int RUN1   = 256 * FRAME1 + 500;

  assign RX  = force0 ? 1'b0 : (glitch ? 1'b0 : (TX ^ inv));
  assign RX2 = TX2;

  uart_link_tester #(.BAUD_DIV(4)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .TX(TX), .RX(RX),
    .FINISHED(FINISHED), .FAILED(FAILED)
  );

  uart_link_tester #(.DATA_BITS(7), .PARITY_ODD(1), .NUM_FRAMES(4)) dut2 (
    .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA2), .TX(TX2), .RX(RX2),
    .FINISHED(FINISHED2), .FAILED(FAILED2)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input bit which, input logic [4:0] a, input logic [7:0] d);
    @(negedge PCLK);
    PSEL = !which; PSEL2 = which; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic chk_reg(input bit which, input logic [4:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    @(negedge PCLK);
    PADDR = a;
    #1;
    d = which ? PRDATA2 : PRDATA;
    check(tag, {8'h00, d}, {8'h00, exp});
  endtask

  function automatic logic get_sig(input bit which, input bit fin);
    if (fin) return which ? FINISHED2 : FINISHED;
    return which ? !TX2 : !TX;
  endfunction

  // Waits for FINISHED (fin=1) or a low TX (fin=0), bounded by a cycle budget.
  task automatic wait_for(input bit which, input bit fin, input int budget, input string tag);
    int n;
    n = 0;
    while (!get_sig(which, fin) && n < budget) begin
      @(posedge PCLK);
      #1;
      n++;
    end
    check(tag, {15'd0, get_sig(which, fin)}, 16'd1);
  endtask

  task automatic chk_clean(input logic [7:0] status, input string tag);
    chk_reg(0, 5'h04, status, {tag, "_status"});
    chk_reg(0, 5'h08, 8'h00,  {tag, "_rxcnt_lo"});
    chk_reg(0, 5'h0C, 8'h01,  {tag, "_rxcnt_hi"});
    chk_reg(0, 5'h10, 8'h00,  {tag, "_dataerr"});
    chk_reg(0, 5'h14, 8'h00,  {tag, "_parerr"});
    chk_reg(0, 5'h18, 8'h00,  {tag, "_frmerr"});
  endtask

  initial begin
    logic [6:0] bits7;
    logic [7:0] d;
    checks = 0; errors = 0;
    PRESETN = 1'b0; PSEL = 1'b0; PSEL2 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; force0 = 1'b0; inv = 1'b0; glitch = 1'b0;
    bits7 = '0;

    // reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("reset_tx", {15'd0, TX}, 16'd1);
    check("reset_finished", {15'd0, FINISHED}, 16'd0);
    check("reset_failed", {15'd0, FAILED}, 16'd0);
    chk_reg(0, 5'h04, 8'h00, "reset_status");
    @(negedge PCLK);
    PRESETN = 1'b1;
    chk_reg(0, 5'h08, 8'h00, "reset_rxcnt_lo");

    // clean loopback run, with a START mid-run that must be ignored
    apb_write(0, 5'h00, 8'h01);
    chk_reg(0, 5'h04, 8'h04, "run1_busy");
    repeat (10 * FRAME1) @(posedge PCLK);
    #1;
    apb_write(0, 5'h00, 8'h01);
    @(negedge PCLK);
    PADDR = 5'h08;
    #1;
    check("start_ignored_rxcnt_nonzero", {15'd0, PRDATA != 8'h00}, 16'd1);
    wait_for(0, 1, RUN1, "run1_finish");
    chk_clean(8'h01, "run1");
    check("run1_tx_idle", {15'd0, TX}, 16'd1);

    // one-cycle low glitch on idle RX must not register a frame
    @(negedge PCLK); glitch = 1'b1;
    @(negedge PCLK); glitch = 1'b0;
    repeat (40) @(posedge PCLK);
    chk_clean(8'h01, "glitch");

    // DUT2: first frame on the wire is 0x61 with odd parity bit 0
    apb_write(1, 5'h00, 8'h01);
    wait_for(1, 0, 100, "dut2_start_bit");
    repeat (8) @(posedge PCLK);
    #1;
    for (int k = 0; k < 7; k++) begin
      repeat (16) @(posedge PCLK);
      #1;
      bits7[k] = TX2;
    end
    check("dut2_data", {9'd0, bits7}, 16'h0061);
    repeat (16) @(posedge PCLK);
    #1;
    check("dut2_parity", {15'd0, TX2}, 16'd0);
    repeat (16) @(posedge PCLK);
    #1;
    check("dut2_stop", {15'd0, TX2}, 16'd1);
    wait_for(1, 1, 2000, "dut2_finish");
    chk_reg(1, 5'h04, 8'h01, "dut2_status");
    chk_reg(1, 5'h08, 8'h04, "dut2_rxcnt");
    chk_reg(1, 5'h10, 8'h00, "dut2_dataerr");

    // RX stuck low from frame 3: framing error, then timeout
    apb_write(0, 5'h00, 8'h01);
    wait_for(0, 0, 100, "stuck_start_bit");
    repeat (2 * FRAME1) @(posedge PCLK);
    #1;
    force0 = 1'b1;
    wait_for(0, 1, 2000, "stuck_finish");
    chk_reg(0, 5'h04, 8'h03, "stuck_status");
    chk_reg(0, 5'h08, 8'h03, "stuck_rxcnt");
    @(negedge PCLK);
    PADDR = 5'h18;
    #1;
    d = PRDATA;
    check("stuck_frmerr_ge1", {15'd0, d >= 8'd1}, 16'd1);
    check("stuck_tx_idle", {15'd0, TX}, 16'd1);
    force0 = 1'b0;

    // invert data bit 0 of frame 5
    apb_write(0, 5'h00, 8'h01);
    wait_for(0, 0, 100, "inv_start_bit");
    repeat (4 * FRAME1 + 4) @(posedge PCLK);
    #1;
    inv = 1'b1;
    repeat (4) @(posedge PCLK);
    #1;
    inv = 1'b0;
    wait_for(0, 1, RUN1, "inv_finish");
    chk_reg(0, 5'h04, 8'h03, "inv_status");
    chk_reg(0, 5'h08, 8'h00, "inv_rxcnt_lo");
    chk_reg(0, 5'h0C, 8'h01, "inv_rxcnt_hi");
    chk_reg(0, 5'h10, 8'h01, "inv_dataerr");
    chk_reg(0, 5'h14, 8'h01, "inv_parerr");
    chk_reg(0, 5'h18, 8'h00, "inv_frmerr");

    // START|ABORT during a run acts as ABORT; counters freeze at 10 frames
    apb_write(0, 5'h00, 8'h01);
    wait_for(0, 0, 100, "abort_start_bit");
    repeat (10 * FRAME1 + 5) @(posedge PCLK);
    #1;
    apb_write(0, 5'h00, 8'h03);
    check("abort_tx", {15'd0, TX}, 16'd1);
    chk_reg(0, 5'h04, 8'h03, "abort_status");
    repeat (100) @(posedge PCLK);
    chk_reg(0, 5'h08, 8'h0A, "abort_rxcnt_held");
    check("abort_tx_later", {15'd0, TX}, 16'd1);

    // reset pulse mid-frame, then a clean run
    apb_write(0, 5'h00, 8'h01);
    wait_for(0, 0, 100, "rst_start_bit");
    repeat (100) @(posedge PCLK);
    #1;
    PRESETN = 1'b0;
    #1;
    check("rst_tx", {15'd0, TX}, 16'd1);
    chk_reg(0, 5'h04, 8'h00, "rst_status");
    chk_reg(0, 5'h08, 8'h00, "rst_rxcnt_lo");
    chk_reg(0, 5'h0C, 8'h00, "rst_rxcnt_hi");
    chk_reg(0, 5'h10, 8'h00, "rst_dataerr");
    chk_reg(0, 5'h18, 8'h00, "rst_frmerr");
    @(negedge PCLK);
    PRESETN = 1'b1;
    apb_write(0, 5'h00, 8'h01);
    wait_for(0, 1, RUN1, "rerun_finish");
    chk_clean(8'h01, "rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
